seq_player: RTL and testbench

- Reader/playback side of the game's sequence storage.
- On `start`, walks addresses `0..length-1` of an external synchronous sequence memory, one read per step.
- Each fetched 4-bit step is presented on `step_out` for a fixed ON time, followed by a blank OFF time, so LED/tone logic downstream can display it.
- Pulses `done` when the whole sequence has been played.

---
 rtl/seq_player.sv | 160 ++++++++++++++++
 tb/tb_seq_player.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_player.sv
// seq_player: playback side of the game's sequence storage.
// Walks addresses 0..length-1 of an external synchronous sequence memory,
// shows each fetched step on step_out for ON_CYCLES cycles, blanks it for
// OFF_CYCLES cycles, then pulses done once the whole sequence has played.
// Optional build macro SEQ_PLAYER_POS_EN adds the step_idx and last_step
// position outputs; without it those ports do not exist.
module seq_player #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] step_out,
    output logic              step_valid,
    output logic              busy,
    output logic              done
`ifdef SEQ_PLAYER_POS_EN
    ,
    output logic [ADDR_W-1:0] step_idx,
    output logic              last_step
`endif
);

    // The phase timer is shared by SHOW and GAP, so it must hold the larger count.
    localparam int TMR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]  ON_LAST  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]  OFF_LAST = TMR_W'(OFF_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
    localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SHOW  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state;
    state_t next_state;

    // The index is one bit wider than the address so a full-depth run can
    // compare index+1 against length=2**ADDR_W without wrapping to zero.
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   index;
    logic [ADDR_W:0]   index_next;
    logic [TMR_W-1:0]  timer;
    logic              last_idx;
    logic              show_end;
    logic              gap_end;

    assign index_next = index + IDX_ONE;
    assign last_idx   = (index_next == len_q);
    assign show_end   = (state == SHOW) && (timer == ON_LAST);
    assign gap_end    = (state == GAP)  && (timer == OFF_LAST);

    // State register; reset and the synchronous state update live here only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort beats every transition, including a start in IDLE.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        next_state = (length == '0) ? DONE : FETCH;
                    end
                end
                FETCH: next_state = WAIT;
                WAIT:  next_state = SHOW;
                SHOW: begin
                    if (show_end) begin
                        next_state = GAP;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        next_state = last_idx ? DONE : FETCH;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Latch the requested length on an accepted start and advance the index per step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q <= '0;
            index <= '0;
        end else if ((state == IDLE) && (next_state == FETCH)) begin
            len_q <= length;
            index <= '0;
        end else if ((state == GAP) && (next_state == FETCH)) begin
            index <= index_next;
        end else if (next_state == IDLE) begin
            index <= '0;
        end
    end

    // Phase timer counts cycles spent in SHOW or GAP and restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (next_state != state) begin
            timer <= '0;
        end else if ((state == SHOW) || (state == GAP)) begin
            timer <= timer + TMR_ONE;
        end else begin
            timer <= '0;
        end
    end

    // Capture read data at the end of WAIT and hold it only while SHOW continues.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_out <= '0;
        end else if (next_state == SHOW) begin
            step_out <= (state == WAIT) ? rd_data : step_out;
        end else begin
            step_out <= '0;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        rd_en      = (state == FETCH);
        rd_addr    = (state == FETCH) ? index[ADDR_W-1:0] : '0;
        step_valid = (state == SHOW);
        busy       = (state != IDLE);
        done       = (state == DONE);
`ifdef SEQ_PLAYER_POS_EN
        step_idx   = ((state == FETCH) || (state == WAIT) ||
                      (state == SHOW)  || (state == GAP)) ? index[ADDR_W-1:0] : '0;
        last_step  = ((state == SHOW) || (state == GAP)) && last_idx;
`endif
    end

endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: self-checking bench for seq_player.
// A cycle-indexed behavioural model predicts every output from the start
// cycle, the latched length and the memory contents; directed sequences
// pin the model with hand-computed cycle numbers, then random traffic
// (starts, aborts, resets, length changes) runs against the model.
module tb_seq_player;

    localparam int AW  = 4;
    localparam int DW  = 4;
    localparam int ON  = 8;
    localparam int OFF = 4;
    localparam int P   = 2 + ON + OFF;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW:0]   length;
    logic          abort;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] step_out;
    logic          step_valid;
    logic          busy;
    logic          done;
`ifdef SEQ_PLAYER_POS_EN
    logic [AW-1:0] step_idx;
    logic          last_step;
`endif

    logic [DW-1:0] mem [16];

    int checks;
    int fails;

    // Model state: playing flag, first FETCH cycle, latched length.
    int cyc;
    bit known;
    bit m_playing;
    int m_first;
    int m_len;

    logic          exp_rd_en;
    int            exp_addr;
    logic          exp_valid;
    int            exp_out;
    logic          exp_busy;
    logic          exp_done;
    int            exp_idx;
    logic          exp_last;

    seq_player #(
        .ADDR_W(AW), .DATA_W(DW), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .length(length),
        .abort(abort),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .step_out(step_out),
        .step_valid(step_valid),
        .busy(busy),
        .done(done)
`ifdef SEQ_PLAYER_POS_EN
        ,
        .step_idx(step_idx),
        .last_step(last_step)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data one cycle after rd_en, random noise otherwise.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= DW'($urandom);
    end

    task automatic checkOutput(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: actual %0d required %0d", nm, cyc, act, exp);
        end
    endtask

    // Compare process: predict this cycle's outputs, compare, then advance the model.
    always @(negedge clk) begin
        if (known) begin
            exp_rd_en = 0; exp_addr = 0; exp_valid = 0; exp_out = 0;
            exp_busy = 0; exp_done = 0; exp_idx = 0; exp_last = 0;
            if (m_playing) begin
                int k, stp, r;
                k = cyc - m_first;
                exp_busy = 1;
                if (k >= m_len * P) begin
                    exp_done = 1;
                end else begin
                    stp = k / P;
                    r   = k % P;
                    exp_rd_en = (r == 0);
                    exp_addr  = stp;
                    exp_valid = (r >= 2) && (r < 2 + ON);
                    exp_out   = exp_valid ? int'(mem[stp]) : 0;
                    exp_idx   = stp;
                    exp_last  = (stp == m_len - 1) && (r >= 2);
                end
            end
            checkOutput("rd_en", int'(rd_en), int'(exp_rd_en));
            if (exp_rd_en) checkOutput("rd_addr", int'(rd_addr), exp_addr);
            checkOutput("step_valid", int'(step_valid), int'(exp_valid));
            checkOutput("step_out", int'(step_out), exp_out);
            checkOutput("busy", int'(busy), int'(exp_busy));
            checkOutput("done", int'(done), int'(exp_done));
`ifdef SEQ_PLAYER_POS_EN
            checkOutput("step_idx", int'(step_idx), exp_idx);
            checkOutput("last_step", int'(last_step), int'(exp_last));
`endif
        end
        if (!rst_n) begin
            known     = 1;
            m_playing = 0;
        end else if (known) begin
            if (abort) begin
                m_playing = 0;
            end else if (m_playing) begin
                if (exp_done) m_playing = 0;
            end else if (start) begin
                m_playing = 1;
                m_first   = cyc + 1;
                m_len     = int'(length);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle, then drive the inputs for the new cycle.
    task automatic applyStimulus(input logic s, input int len, input logic ab);
        tick();
        start  = s;
        length = (AW+1)'(len);
        abort  = ab;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0);
    endtask

    task automatic runBasic();
        mem[0] = 4'h3; mem[1] = 4'hA; mem[2] = 4'h5;
        applyStimulus(1'b1, 3, 1'b0);
        for (int c = 1; c <= 45; c++) begin
            applyStimulus(1'b0, 3, 1'b0);
            case (c)
                1:  begin checkOutput("basic_rd_c1", int'(rd_en), 1);
                          checkOutput("basic_addr_c1", int'(rd_addr), 0); end
                2:  checkOutput("basic_valid_c2", int'(step_valid), 0);
                3:  begin checkOutput("basic_valid_c3", int'(step_valid), 1);
                          checkOutput("basic_out_c3", int'(step_out), 3); end
                10: checkOutput("basic_valid_c10", int'(step_valid), 1);
                11: begin checkOutput("basic_valid_c11", int'(step_valid), 0);
                          checkOutput("basic_out_c11", int'(step_out), 0); end
                15: begin checkOutput("basic_rd_c15", int'(rd_en), 1);
                          checkOutput("basic_addr_c15", int'(rd_addr), 1); end
                17: begin checkOutput("basic_out_c17", int'(step_out), 10);
`ifdef SEQ_PLAYER_POS_EN
                          checkOutput("basic_idx_c17", int'(step_idx), 1);
`endif
                    end
                29: begin checkOutput("basic_rd_c29", int'(rd_en), 1);
                          checkOutput("basic_addr_c29", int'(rd_addr), 2); end
                30: begin
`ifdef SEQ_PLAYER_POS_EN
                          checkOutput("basic_last_c30", int'(last_step), 0);
`endif
                          checkOutput("basic_busy_c30", int'(busy), 1); end
                31: begin checkOutput("basic_out_c31", int'(step_out), 5);
`ifdef SEQ_PLAYER_POS_EN
                          checkOutput("basic_last_c31", int'(last_step), 1);
                          checkOutput("basic_idx_c31", int'(step_idx), 2);
`endif
                    end
                42: begin checkOutput("basic_done_c42", int'(done), 0);
`ifdef SEQ_PLAYER_POS_EN
                          checkOutput("basic_last_c42", int'(last_step), 1);
`endif
                    end
                43: begin checkOutput("basic_done_c43", int'(done), 1);
                          checkOutput("basic_busy_c43", int'(busy), 1);
`ifdef SEQ_PLAYER_POS_EN
                          checkOutput("basic_last_c43", int'(last_step), 0);
`endif
                    end
                44: begin checkOutput("basic_done_c44", int'(done), 0);
                          checkOutput("basic_busy_c44", int'(busy), 0); end
                default: ;
            endcase
        end
    endtask

    initial begin
        int reads, dones, last_addr;
        checks = 0; fails = 0; cyc = 0;
        known = 0; m_playing = 0; m_first = 0; m_len = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset held for two edges with start high.
        rst_n = 1'b0; start = 1'b1; length = 5'd3; abort = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        rst_n = 1'b1; start = 1'b0;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_rd_en", int'(rd_en), 0);
        checkOutput("rst_step_out", int'(step_out), 0);
        checkOutput("rst_done", int'(done), 0);
        idleCycles(3);
        checkOutput("rst_idle_rd_en", int'(rd_en), 0);

        runBasic();

        // Zero length: done next cycle, no read.
        applyStimulus(1'b1, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("zero_done_c1", int'(done), 1);
        checkOutput("zero_rd_c1", int'(rd_en), 0);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("zero_busy_c2", int'(busy), 0);

        // Full depth: exactly 16 reads ending at address 15, one done.
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
        reads = 0; dones = 0; last_addr = -1;
        applyStimulus(1'b1, 16, 1'b0);
        for (int c = 1; c <= 16 * P + 6; c++) begin
            applyStimulus(1'b0, 16, 1'b0);
            if (rd_en) begin reads++; last_addr = int'(rd_addr); end
            if (done) dones++;
        end
        checkOutput("full_reads", reads, 16);
        checkOutput("full_last_addr", last_addr, 15);
        checkOutput("full_dones", dones, 1);

        // Abort during SHOW of the second step, with an ignored mid-run start.
        mem[0] = 4'h3; mem[1] = 4'hA; mem[2] = 4'h5;
        dones = 0;
        applyStimulus(1'b1, 3, 1'b0);
        for (int c = 1; c <= 50; c++) begin
            applyStimulus((c == 5) ? 1'b1 : 1'b0, (c == 5) ? 1 : 3, (c == 20) ? 1'b1 : 1'b0);
            if (c == 20) checkOutput("abort_valid_c20", int'(step_valid), 1);
            if (c == 21) begin
                checkOutput("abort_valid_c21", int'(step_valid), 0);
                checkOutput("abort_busy_c21", int'(busy), 0);
                checkOutput("abort_out_c21", int'(step_out), 0);
            end
            if (done) dones++;
        end
        checkOutput("abort_no_done", dones, 0);
        applyStimulus(1'b1, 2, 1'b0);
        applyStimulus(1'b0, 2, 1'b0);
        checkOutput("restart_rd_c1", int'(rd_en), 1);
        checkOutput("restart_addr_c1", int'(rd_addr), 0);
        idleCycles(2 * P + 4);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 4);
            applyStimulus(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, len,
                          ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
            rst_n = ($urandom_range(0, 399) != 0) ? 1'b1 : 1'b0;
            if (!m_playing && !start && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
            end
        end
        rst_n = 1'b1;
        idleCycles(16 * P + 10);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
